// File: rtl/scoreboard_spec_gen.sv
// ---------------------------------------------------------------------------
// scoreboard_spec_gen
//
// Register-status scoreboard for the tensor-core scalar/matrix/GEMM pipeline.
// Tracks which architectural registers have a write in flight (and which FU
// owns that write), which functional units are occupied, and one level of
// branch speculation. Dispatch is gated on RAW, WAW, structural and branch
// hazards; accepted instructions produce a registered one-cycle issue pulse.
//
// Optional feature (compile-time macro SCOREBOARD_WB_BYPASS_EN):
//   defined   : a writeback in the current cycle removes the hazard it clears,
//               so a dependent instruction can dispatch in that same cycle.
//   undefined : hazards look at registered state only; the dependent
//               instruction dispatches one cycle after the writeback.
//
// Handshake: disp_valid/disp_ready follow valid/ready semantics. disp_ready is
// a combinational function of registered state and same-cycle writeback /
// branch-resolve inputs; it never depends on disp_valid. An instruction is
// accepted (fires) in exactly the cycles where disp_valid && disp_ready is
// high at the rising edge of CLK. disp_* inputs need only be stable then.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   disp_*              decoded instruction (valid/ready, register fields,
//                       field-used flags, target FU, branch flag)
//   wb_*                NUM_WB packed writeback ports from FU completion buses
//   branch_resolved/miss outstanding-branch resolution (miss qualified by
//                       resolved)
//   iss_*               registered issue pulse and its FU / rd / spec tag
//   fu_busy             per-FU occupancy
//   spec_active         an unresolved branch is outstanding
//   dbg_state           FSM state (0 = IDLE, 1 = SPEC) for debug/checkers
// ---------------------------------------------------------------------------
module scoreboard_spec_gen #(
  parameter int NUM_REGS = 32,
  parameter int NUM_FU   = 4,
  parameter int NUM_WB   = 2,
  parameter int ZERO_REG = 1,
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int FU_W    = $clog2(NUM_FU)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [REG_W-1:0]        disp_rd,
  input  logic [REG_W-1:0]        disp_rs1,
  input  logic [REG_W-1:0]        disp_rs2,
  input  logic                    disp_rd_en,
  input  logic                    disp_rs1_en,
  input  logic                    disp_rs2_en,
  input  logic [FU_W-1:0]         disp_fu,
  input  logic                    disp_is_branch,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*FU_W-1:0]  wb_fu,
  input  logic [NUM_WB*REG_W-1:0] wb_rd,
  input  logic [NUM_WB-1:0]       wb_rd_en,
  input  logic                    branch_resolved,
  input  logic                    branch_miss,
  output logic                    iss_valid,
  output logic [FU_W-1:0]         iss_fu,
  output logic [REG_W-1:0]        iss_rd,
  output logic                    iss_spec,
  output logic [NUM_FU-1:0]       fu_busy,
  output logic                    spec_active,
  output logic                    dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    SPEC = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Per-register state
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] rspec_q, rspec_d;
  logic [FU_W-1:0]     owner_q [NUM_REGS];
  logic [FU_W-1:0]     owner_d [NUM_REGS];

  // Per-FU state
  logic [NUM_FU-1:0]   busy_q, busy_d;
  logic [NUM_FU-1:0]   fspec_q, fspec_d;

  // Issue output registers
  logic                iss_valid_q, iss_valid_d;
  logic [FU_W-1:0]     iss_fu_q, iss_fu_d;
  logic [REG_W-1:0]    iss_rd_q, iss_rd_d;
  logic                iss_spec_q, iss_spec_d;

  // With ZERO_REG set, register 0 is invisible to the scoreboard.
  function automatic logic is_zero(input logic [REG_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // -------------------------------------------------------------------------
  // Writeback decode: which pending bits and busy bits the ports clear this
  // cycle. A register clear needs the completing FU to be the recorded owner;
  // a writeback from a stale owner (the register was re-targeted since) must
  // not release the newer in-flight write.
  // -------------------------------------------------------------------------
  logic [NUM_REGS-1:0] wb_pend_clr;
  logic [NUM_FU-1:0]   wb_busy_clr;

  always_comb begin
    wb_pend_clr = '0;
    wb_busy_clr = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) begin
        wb_busy_clr[wb_fu[k*FU_W +: FU_W]] = 1'b1;
        if (wb_rd_en[k] &&
            (owner_q[wb_rd[k*REG_W +: REG_W]] == wb_fu[k*FU_W +: FU_W])) begin
          wb_pend_clr[wb_rd[k*REG_W +: REG_W]] = 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Hazard view of the state: registered, or with same-cycle writebacks
  // already applied when the bypass is built in.
  // -------------------------------------------------------------------------
  logic [NUM_REGS-1:0] pend_view;
  logic [NUM_FU-1:0]   busy_view;

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign pend_view = pending_q & ~wb_pend_clr;
  assign busy_view = busy_q & ~wb_busy_clr;
`else
  assign pend_view = pending_q;
  assign busy_view = busy_q;
`endif

  logic in_spec;
  logic resolve;
  logic squash;
  logic raw_haz, waw_haz, struct_haz, branch_haz;
  logic fire;
  logic spec_tag;

  assign in_spec = (state_q == SPEC);
  // Resolution only means something while a branch is outstanding.
  assign resolve = in_spec && branch_resolved;
  assign squash  = resolve && branch_miss;

  assign raw_haz = (disp_rs1_en && !is_zero(disp_rs1) && pend_view[disp_rs1]) ||
                   (disp_rs2_en && !is_zero(disp_rs2) && pend_view[disp_rs2]);
  assign waw_haz = disp_rd_en && !is_zero(disp_rd) && pend_view[disp_rd];
  assign struct_haz = busy_view[disp_fu];
  // Only one level of speculation: a second branch waits for the first.
  assign branch_haz = disp_is_branch && in_spec;

  assign disp_ready = !(raw_haz || waw_haz || struct_haz || branch_haz || squash);
  assign fire       = disp_valid && disp_ready;

  // An instruction accepted in the cycle a branch resolves as a hit is no
  // longer under an unresolved branch, so it is tagged non-speculative.
  // Otherwise it would keep a spec bit after the spec window closed.
  assign spec_tag = in_spec && !branch_resolved;

  // -------------------------------------------------------------------------
  // Next-state logic. Order matters: writeback clears, then branch resolve
  // (squash), then dispatch sets, so a same-cycle dispatch set wins.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q & ~wb_pend_clr;
    busy_d      = busy_q & ~wb_busy_clr;
    rspec_d     = rspec_q;
    fspec_d     = fspec_q;
    owner_d     = owner_q;
    iss_valid_d = 1'b0;
    iss_fu_d    = iss_fu_q;
    iss_rd_d    = iss_rd_q;
    iss_spec_d  = iss_spec_q;

    case (state_q)
      IDLE: begin
        if (fire && disp_is_branch) begin
          state_d = SPEC;
        end
      end
      SPEC: begin
        if (branch_resolved) begin
          state_d = IDLE;
          if (branch_miss) begin
            // Squash everything issued under the branch; non-speculative
            // entries are left exactly as writeback made them.
            pending_d = pending_d & ~rspec_q;
            busy_d    = busy_d & ~fspec_q;
          end
          rspec_d = '0;
          fspec_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fire) begin
      if (disp_rd_en && !is_zero(disp_rd)) begin
        pending_d[disp_rd] = 1'b1;
        owner_d[disp_rd]   = disp_fu;
        rspec_d[disp_rd]   = spec_tag;
      end
      busy_d[disp_fu]  = 1'b1;
      fspec_d[disp_fu] = spec_tag;
      iss_valid_d      = 1'b1;
      iss_fu_d         = disp_fu;
      iss_rd_d         = disp_rd;
      iss_spec_d       = spec_tag;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rspec_q     <= '0;
      busy_q      <= '0;
      fspec_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_fu_q    <= '0;
      iss_rd_q    <= '0;
      iss_spec_q  <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        owner_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rspec_q     <= rspec_d;
      busy_q      <= busy_d;
      fspec_q     <= fspec_d;
      iss_valid_q <= iss_valid_d;
      iss_fu_q    <= iss_fu_d;
      iss_rd_q    <= iss_rd_d;
      iss_spec_q  <= iss_spec_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        owner_q[r] <= owner_d[r];
      end
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_fu      = iss_fu_q;
  assign iss_rd      = iss_rd_q;
  assign iss_spec    = iss_spec_q;
  assign fu_busy     = busy_q;
  assign spec_active = in_spec;
  assign dbg_state   = in_spec;

endmodule

// File: tb/tb_scoreboard_spec_gen.sv
// ---------------------------------------------------------------------------
// tb_scoreboard_spec_gen
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the scoreboard (plain per-register / per-FU arrays updated by the rules of
// the block) predicts disp_ready every cycle and the registered outputs after
// every edge; issued instructions are also tracked through an expected queue.
// ---------------------------------------------------------------------------
module tb_scoreboard_spec_gen;

  localparam int NUM_REGS = 32;
  localparam int NUM_FU   = 4;
  localparam int NUM_WB   = 2;
  localparam int REG_W    = 5;
  localparam int FU_W     = 2;
  localparam int IW       = 1 + REG_W + FU_W;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic                    disp_valid, disp_ready;
  logic [REG_W-1:0]        disp_rd, disp_rs1, disp_rs2;
  logic                    disp_rd_en, disp_rs1_en, disp_rs2_en;
  logic [FU_W-1:0]         disp_fu;
  logic                    disp_is_branch;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*FU_W-1:0]  wb_fu;
  logic [NUM_WB*REG_W-1:0] wb_rd;
  logic [NUM_WB-1:0]       wb_rd_en;
  logic                    branch_resolved, branch_miss;
  logic                    iss_valid;
  logic [FU_W-1:0]         iss_fu;
  logic [REG_W-1:0]        iss_rd;
  logic                    iss_spec;
  logic [NUM_FU-1:0]       fu_busy;
  logic                    spec_active;
  logic                    dbg_state;

  scoreboard_spec_gen #(
    .NUM_REGS(NUM_REGS), .NUM_FU(NUM_FU), .NUM_WB(NUM_WB), .ZERO_REG(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rd_en(disp_rd_en), .disp_rs1_en(disp_rs1_en), .disp_rs2_en(disp_rs2_en),
    .disp_fu(disp_fu), .disp_is_branch(disp_is_branch),
    .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_rd(wb_rd), .wb_rd_en(wb_rd_en),
    .branch_resolved(branch_resolved), .branch_miss(branch_miss),
    .iss_valid(iss_valid), .iss_fu(iss_fu), .iss_rd(iss_rd), .iss_spec(iss_spec),
    .fu_busy(fu_busy), .spec_active(spec_active), .dbg_state(dbg_state)
  );

  // ---------------- behavioural model ----------------
  bit m_pend  [NUM_REGS];
  int m_owner [NUM_REGS];
  bit m_rspec [NUM_REGS];
  bit m_busy  [NUM_FU];
  bit m_fspec [NUM_FU];
  bit m_spec_active;
  bit e_iss_valid, e_iss_spec;
  int e_iss_fu, e_iss_rd;

  logic [IW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wfu(input int k);
    return int'(wb_fu[k*FU_W +: FU_W]);
  endfunction

  function automatic int wrd(input int k);
    return int'(wb_rd[k*REG_W +: REG_W]);
  endfunction

  // Would the current instruction be accepted this cycle?
  function automatic bit m_ready();
    bit pv[NUM_REGS];
    bit bv[NUM_FU];
    pv = m_pend;
    bv = m_busy;
`ifdef SCOREBOARD_WB_BYPASS_EN
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) begin
        bv[wfu(k)] = 1'b0;
        if (wb_rd_en[k] && m_owner[wrd(k)] == wfu(k)) pv[wrd(k)] = 1'b0;
      end
    end
`endif
    // register 0 is never pending in the model, so it never blocks
    if (disp_rs1_en && pv[disp_rs1]) return 1'b0;
    if (disp_rs2_en && pv[disp_rs2]) return 1'b0;
    if (disp_rd_en && pv[disp_rd]) return 1'b0;
    if (bv[disp_fu]) return 1'b0;
    if (disp_is_branch && m_spec_active) return 1'b0;
    if (m_spec_active && branch_resolved && branch_miss) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model across one rising edge with the current inputs.
  task automatic m_step(input bit fire);
    bit tag;
    if (RST) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        m_pend[r] = 0; m_owner[r] = 0; m_rspec[r] = 0;
      end
      for (int f = 0; f < NUM_FU; f++) begin
        m_busy[f] = 0; m_fspec[f] = 0;
      end
      m_spec_active = 0;
      e_iss_valid = 0; e_iss_fu = 0; e_iss_rd = 0; e_iss_spec = 0;
      exp_q.delete();
      return;
    end
    tag = m_spec_active && !branch_resolved;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) begin
        m_busy[wfu(k)] = 0;
        if (wb_rd_en[k] && m_owner[wrd(k)] == wfu(k)) m_pend[wrd(k)] = 0;
      end
    end
    if (m_spec_active && branch_resolved) begin
      if (branch_miss) begin
        for (int r = 0; r < NUM_REGS; r++) if (m_rspec[r]) m_pend[r] = 0;
        for (int f = 0; f < NUM_FU; f++) if (m_fspec[f]) m_busy[f] = 0;
      end
      for (int r = 0; r < NUM_REGS; r++) m_rspec[r] = 0;
      for (int f = 0; f < NUM_FU; f++) m_fspec[f] = 0;
      m_spec_active = 0;
    end
    e_iss_valid = fire;
    if (fire) begin
      if (disp_rd_en && disp_rd != 0) begin
        m_pend[disp_rd] = 1; m_owner[disp_rd] = int'(disp_fu); m_rspec[disp_rd] = tag;
      end
      m_busy[disp_fu] = 1;
      m_fspec[disp_fu] = tag;
      if (disp_is_branch) m_spec_active = 1;
      e_iss_fu = int'(disp_fu); e_iss_rd = int'(disp_rd); e_iss_spec = tag;
      exp_q.push_back({tag, disp_rd, disp_fu});
    end
  endtask

  // ---------------- compare process (one call per clock) ----------------
  task automatic cycle(input int lit = -1, input string nm = "ready_literal");
    bit rdy;
    logic [NUM_FU-1:0] bvec;
    logic [IW-1:0] item;
    #1;
    rdy = m_ready();
    chk("disp_ready", disp_ready, rdy);
    if (lit >= 0) chk(nm, disp_ready, lit);
    @(posedge CLK);
    m_step(disp_valid && rdy);
    #1;
    for (int f = 0; f < NUM_FU; f++) bvec[f] = m_busy[f];
    chk("iss_valid", iss_valid, e_iss_valid);
    chk("iss_fu", iss_fu, e_iss_fu);
    chk("iss_rd", iss_rd, e_iss_rd);
    chk("iss_spec", iss_spec, e_iss_spec);
    chk("fu_busy", fu_busy, bvec);
    chk("spec_active", spec_active, m_spec_active);
    chk("dbg_state", dbg_state, m_spec_active);
    if (iss_valid === 1'b1) begin
      chk("iss_queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        chk("iss_queue_item", {iss_spec, iss_rd, iss_fu}, item);
      end
    end
    @(negedge CLK);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_in();
    disp_valid = 0; disp_rd = 0; disp_rs1 = 0; disp_rs2 = 0;
    disp_rd_en = 0; disp_rs1_en = 0; disp_rs2_en = 0;
    disp_fu = 0; disp_is_branch = 0;
    wb_valid = 0; wb_fu = 0; wb_rd = 0; wb_rd_en = 0;
    branch_resolved = 0; branch_miss = 0;
  endtask

  task automatic disp(input int fu, input int rd, input bit rd_en,
                      input int rs1, input bit rs1_en, input bit br);
    disp_valid = 1; disp_fu = FU_W'(fu);
    disp_rd = REG_W'(rd); disp_rd_en = rd_en;
    disp_rs1 = REG_W'(rs1); disp_rs1_en = rs1_en;
    disp_rs2 = 0; disp_rs2_en = 0;
    disp_is_branch = br;
  endtask

  task automatic wb(input int k, input int fu, input int rd, input bit rd_en);
    wb_valid[k] = 1;
    wb_fu[k*FU_W +: FU_W] = FU_W'(fu);
    wb_rd[k*REG_W +: REG_W] = REG_W'(rd);
    wb_rd_en[k] = rd_en;
  endtask

  task automatic rand_in();
    int rd;
    disp_valid = ($urandom_range(0, 3) != 0);
    disp_rd = REG_W'($urandom_range(0, 7));
    disp_rs1 = REG_W'($urandom_range(0, 7));
    disp_rs2 = REG_W'($urandom_range(0, 7));
    disp_rd_en = 1'($urandom_range(0, 1));
    disp_rs1_en = 1'($urandom_range(0, 1));
    disp_rs2_en = 1'($urandom_range(0, 1));
    disp_fu = FU_W'($urandom_range(0, 3));
    disp_is_branch = ($urandom_range(0, 9) == 0);
    for (int k = 0; k < NUM_WB; k++) begin
      wb_valid[k] = ($urandom_range(0, 2) == 0);
      rd = $urandom_range(0, 7);
      wb_rd[k*REG_W +: REG_W] = REG_W'(rd);
      wb_fu[k*FU_W +: FU_W] = ($urandom_range(0, 1) != 0) ? FU_W'(m_owner[rd])
                                                          : FU_W'($urandom_range(0, 3));
      wb_rd_en[k] = ($urandom_range(0, 3) != 0);
    end
    branch_resolved = ($urandom_range(0, 5) == 0);
    branch_miss = 1'($urandom_range(0, 1));
    RST = ($urandom_range(0, 199) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1;
    idle_in();
    @(negedge CLK);
    cycle();
    cycle();
    RST = 0;
    chk("rst_fu_busy", fu_busy, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_spec_active", spec_active, 0);

    // RAW through a writeback
    idle_in(); disp(1, 5, 1, 0, 0, 0); cycle(1, "raw_first_ready");
    chk("raw_iss_fu1", iss_fu, 1);
    chk("raw_busy", fu_busy, 4'b0010);
    idle_in(); disp(2, 0, 0, 5, 1, 0); cycle(0, "raw_blocked_ready");
    idle_in(); disp(2, 0, 0, 5, 1, 0); wb(0, 1, 5, 1);
`ifdef SCOREBOARD_WB_BYPASS_EN
    cycle(1, "raw_bypass_ready");
`else
    cycle(0, "raw_wb_cycle_ready");
    idle_in(); disp(2, 0, 0, 5, 1, 0); cycle(1, "raw_after_wb_ready");
`endif
    chk("raw_iss_valid", iss_valid, 1);
    chk("raw_iss_fu2", iss_fu, 2);
    idle_in(); wb(0, 2, 0, 0); cycle();

    // structural hazard and stale owner
    idle_in(); disp(0, 3, 1, 0, 0, 0); cycle(1, "st_disp_ready");
    idle_in(); disp(0, 9, 1, 0, 0, 0); cycle(0, "struct_busy_ready");
    idle_in(); wb(0, 2, 3, 1); cycle();
    idle_in(); disp(1, 0, 0, 3, 1, 0); cycle(0, "stale_owner_ready");
    idle_in(); wb(0, 0, 3, 1); cycle();
    chk("st_fu_busy", fu_busy, 4'b0000);
    idle_in(); disp(1, 0, 0, 3, 1, 0); cycle(1, "st_cleared_ready");
    idle_in(); wb(0, 1, 0, 0); cycle();

    // branch hit
    idle_in(); disp(3, 0, 0, 0, 0, 1); cycle(1, "hit_br_ready");
    chk("hit_spec_active", spec_active, 1);
    chk("hit_br_iss_spec", iss_spec, 0);
    idle_in(); disp(1, 7, 1, 0, 0, 0); cycle(1, "hit_rd7_ready");
    chk("hit_iss_spec", iss_spec, 1);
    idle_in(); branch_resolved = 1; cycle();
    chk("hit_resolved_spec", spec_active, 0);
    idle_in(); disp(2, 0, 0, 7, 1, 0); cycle(0, "hit_pend7_ready");
    idle_in(); wb(0, 3, 0, 0); wb(1, 1, 7, 1); cycle();

    // branch miss
    idle_in(); disp(0, 4, 1, 0, 0, 0); cycle(1, "miss_rd4_ready");
    idle_in(); disp(3, 0, 0, 0, 0, 1); cycle(1, "miss_br_ready");
    idle_in(); disp(1, 7, 1, 0, 0, 0); cycle(1, "miss_rd7_ready");
    idle_in(); disp(2, 0, 0, 0, 0, 0); branch_resolved = 1; branch_miss = 1;
    cycle(0, "miss_squash_ready");
    chk("miss_fu_busy", fu_busy, 4'b1001);
    chk("miss_spec_active", spec_active, 0);
    idle_in(); disp(2, 0, 0, 7, 1, 0); cycle(1, "miss_pend7_ready");
    idle_in(); disp(1, 0, 0, 4, 1, 0); cycle(0, "miss_pend4_ready");
    idle_in(); wb(0, 0, 4, 1); wb(1, 2, 0, 0); cycle();
    idle_in(); wb(0, 3, 0, 0); cycle();
    chk("miss_clean_busy", fu_busy, 4'b0000);

    // zero register and a second branch
    idle_in(); disp(0, 0, 1, 0, 0, 0); cycle(1, "zero_rd_ready");
    idle_in(); disp(1, 0, 1, 0, 1, 0); disp_rs2_en = 1; cycle(1, "zero_reg_ready");
    idle_in(); disp(2, 0, 0, 0, 0, 1); cycle(1, "br1_ready");
    idle_in(); disp(3, 0, 0, 0, 0, 1); cycle(0, "second_br_ready");
    idle_in(); disp(3, 0, 0, 0, 0, 1); branch_resolved = 1;
    cycle(0, "br_resolve_cycle_ready");
    idle_in(); disp(3, 0, 0, 0, 0, 1); cycle(1, "br_after_resolve_ready");
    idle_in(); branch_resolved = 1; wb(0, 0, 0, 0); wb(1, 1, 0, 0); cycle();
    idle_in(); wb(0, 2, 0, 0); wb(1, 3, 0, 0); cycle();

    // reset in the middle of a spec window with three pending registers
    idle_in(); disp(0, 0, 0, 0, 0, 1); cycle();
    idle_in(); disp(1, 1, 1, 0, 0, 0); cycle();
    idle_in(); disp(2, 2, 1, 0, 0, 0); cycle();
    idle_in(); disp(3, 3, 1, 0, 0, 0); cycle();
    idle_in(); RST = 1; wb(0, 1, 1, 1); branch_resolved = 1; cycle();
    RST = 0;
    chk("rst_mid_iss_valid", iss_valid, 0);
    chk("rst_mid_iss_fu", iss_fu, 0);
    chk("rst_mid_iss_rd", iss_rd, 0);
    chk("rst_mid_iss_spec", iss_spec, 0);
    chk("rst_mid_busy", fu_busy, 0);
    chk("rst_mid_spec", spec_active, 0);
    chk("rst_mid_state", dbg_state, 0);
    idle_in(); disp(1, 0, 0, 3, 1, 0); cycle(1, "post_rst_ready");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      cycle();
    end
    RST = 0;
    idle_in();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
